parking_gate_controller: RTL and testbench
==========================================

Name: parking_gate_controller

Overview:
- Car-park entrance controller FSM.
- Detects a car at the entrance sensor and waits a fixed settling time.
- Checks a two-part password, then drives green/red gate LEDs and two 7-segment status digits.
- Sits between the sensor/keypad inputs and the gate indicator display; single clock domain.

Parameters:
- WAIT_CYCLES, 4: cycles spent in WAIT_PASSWORD before the password is evaluated; must be >= 1.
- PASS1, 2'b01: required value of password_1.
- PASS2, 2'b10: required value of password_2.
- CNT_W, 32: width of the wait counter.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  reset; asynchronous, active-high (asserted when 1, despite the suffix).
- sensor_entrance  in  1  car present at the entrance.
- sensor_exit  in  1  car passed the exit sensor.
- password_1  in  2  first password field.
- password_2  in  2  second password field.
- GREEN_LED  out  1  gate-open indicator.
- RED_LED  out  1  gate-closed/alarm indicator.
- HEX_1  out  7  left digit, active-low segments, bit order {g,f,e,d,c,b,a}.
- HEX_2  out  7  right digit, same encoding.

Behaviour:
- Reset (reset_n=1, async, any time including mid-sequence):
  - state=IDLE, counter=0, GREEN_LED=0, RED_LED=0.
  - HEX_1 and HEX_2 are 7'h7F (blank) on release.
- pass_ok = (password_1==PASS1) && (password_2==PASS2).
- States and transitions, evaluated each rising edge:
  - IDLE: sensor_entrance=1 -> WAIT_PASSWORD; else stay.
  - WAIT_PASSWORD: counter increments each cycle. When counter==WAIT_CYCLES-1: pass_ok -> RIGHT_PASS, else -> WRONG_PASS. Password is sampled only on that edge.
  - WRONG_PASS: pass_ok -> RIGHT_PASS; else stay.
  - RIGHT_PASS, in priority order:
    - sensor_entrance=1 and sensor_exit=1 -> STOP (next car tailgating).
    - sensor_exit=1 alone -> IDLE.
    - otherwise stay.
  - STOP: pass_ok -> RIGHT_PASS; else stay.
- Counter: cleared to 0 in every state other than WAIT_PASSWORD, and on leaving WAIT_PASSWORD. Never wraps, since it stops at WAIT_CYCLES-1.
- LEDs are registered and updated on the same edge as state, based on the next state:
  - next IDLE: green=0, red=0.
  - next WAIT_PASSWORD: green=0, red=1.
  - next WRONG_PASS or STOP: green=0, red toggles.
  - next RIGHT_PASS: red=0, green toggles. First entry from green=0 gives green=1, so green is high the cycle after entry.
- HEX is combinational from the current state:
  - IDLE: 7'h7F / 7'h7F (blank).
  - WAIT_PASSWORD: 7'h06 'E' / 7'h2B 'n'.
  - WRONG_PASS: 7'h06 'E' / 7'h06 'E'.
  - RIGHT_PASS: 7'h02 '6' / 7'h40 '0' ("GO").
  - STOP: 7'h12 'S' / 7'h0C 'P'.
- Latency:
  - IDLE->WAIT_PASSWORD: 1 cycle after sensor_entrance.
  - WAIT_PASSWORD->decision: exactly WAIT_CYCLES cycles in WAIT_PASSWORD.
- sensor_entrance is ignored outside IDLE and RIGHT_PASS. sensor_exit is ignored outside RIGHT_PASS.
- Illegal state encodings recover to IDLE next edge.

Test Plan:
- Reset mid-WAIT_PASSWORD: assert reset_n=1 -> immediately IDLE, LEDs 0, HEX 7F/7F, counter 0; release, then sensor_entrance=1 -> HEX 06/2B, RED_LED=1 next edge.
- Correct password (01,10) held during wait -> after 4 cycles in WAIT_PASSWORD: HEX 02/40, GREEN_LED=1, then toggles 0,1,0 each cycle, RED_LED=0.
- Wrong password (00,00) -> WRONG_PASS: HEX 06/06, RED_LED toggles each cycle. Then apply (01,10) -> RIGHT_PASS next edge, GREEN_LED=1.
- In RIGHT_PASS, sensor_exit=1 alone -> IDLE: HEX 7F/7F, both LEDs 0.
- In RIGHT_PASS, sensor_entrance=1 and sensor_exit=1 together -> STOP: HEX 12/0C, red toggling. Wrong password holds STOP; (01,10) -> RIGHT_PASS.
- Password changed to wrong before the 4th WAIT cycle -> WRONG_PASS, proving only the decision-edge sample matters.

Source files
------------

// File: rtl/parking_gate_controller.sv
// Car-park entrance gate controller: detects a car, waits a settling time,
// checks a two-field password and drives gate LEDs plus two 7-segment digits.
module parking_gate_controller #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter logic [1:0]  PASS1       = 2'b01,
    parameter logic [1:0]  PASS2       = 2'b10,
    parameter int          CNT_W       = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor_entrance,
    input  logic       sensor_exit,
    input  logic [1:0] password_1,
    input  logic [1:0] password_2,
    output logic       GREEN_LED,
    output logic       RED_LED,
    output logic [6:0] HEX_1,
    output logic [6:0] HEX_2
);

    localparam logic [2:0] IDLE          = 3'd0;
    localparam logic [2:0] WAIT_PASSWORD = 3'd1;
    localparam logic [2:0] WRONG_PASS    = 3'd2;
    localparam logic [2:0] RIGHT_PASS    = 3'd3;
    localparam logic [2:0] STOP          = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] counter;
    logic             pass_ok;

    assign pass_ok = (password_1 == PASS1) && (password_2 == PASS2);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:          if (sensor_entrance) next_state = WAIT_PASSWORD;
            WAIT_PASSWORD: if (counter == CNT_LAST)
                               next_state = pass_ok ? RIGHT_PASS : WRONG_PASS;
            WRONG_PASS:    if (pass_ok) next_state = RIGHT_PASS;
            RIGHT_PASS: begin
                if (sensor_entrance && sensor_exit) next_state = STOP;
                else if (sensor_exit)               next_state = IDLE;
            end
            STOP:          if (pass_ok) next_state = RIGHT_PASS;
            default:       next_state = IDLE;
        endcase
    end

    // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state     <= IDLE;
            counter   <= '0;
            GREEN_LED <= 1'b0;
            RED_LED   <= 1'b0;
        end else begin
            state <= next_state;
            // Counting only while staying in the wait state also clears it on exit.
            if (state == WAIT_PASSWORD && next_state == WAIT_PASSWORD)
                counter <= counter + CNT_W'(1);
            else
                counter <= '0;

            case (next_state)
                WAIT_PASSWORD: begin
                    GREEN_LED <= 1'b0;
                    RED_LED   <= 1'b1;
                end
                WRONG_PASS, STOP: begin
                    GREEN_LED <= 1'b0;
                    RED_LED   <= ~RED_LED;
                end
                RIGHT_PASS: begin
                    GREEN_LED <= ~GREEN_LED;
                    RED_LED   <= 1'b0;
                end
                default: begin
                    GREEN_LED <= 1'b0;
                    RED_LED   <= 1'b0;
                end
            endcase
        end
    end

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        HEX_1 = 7'h7F;
        HEX_2 = 7'h7F;
        case (state)
            WAIT_PASSWORD: begin HEX_1 = 7'h06; HEX_2 = 7'h2B; end
            WRONG_PASS:    begin HEX_1 = 7'h06; HEX_2 = 7'h06; end
            RIGHT_PASS:    begin HEX_1 = 7'h02; HEX_2 = 7'h40; end
            STOP:          begin HEX_1 = 7'h12; HEX_2 = 7'h0C; end
            default:       begin HEX_1 = 7'h7F; HEX_2 = 7'h7F; end
        endcase
    end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench for parking_gate_controller: a phase-level reference model
// queues expected outputs per edge; a monitor pops and compares after each edge.
module tb_parking_gate_controller;

    localparam int WAIT_CYCLES = 4;

    logic       clk;
    logic       reset_n;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       GREEN_LED;
    logic       RED_LED;
    logic [6:0] HEX_1;
    logic [6:0] HEX_2;

    parking_gate_controller #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .PASS1      (2'b01),
        .PASS2      (2'b10),
        .CNT_W      (32)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sensor_entrance(sensor_entrance),
        .sensor_exit    (sensor_exit),
        .password_1     (password_1),
        .password_2     (password_2),
        .GREEN_LED      (GREEN_LED),
        .RED_LED        (RED_LED),
        .HEX_1          (HEX_1),
        .HEX_2          (HEX_2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef enum {P_IDLE, P_WAIT, P_WRONG, P_GO, P_STOP} phase_t;

    phase_t      ph;
    int          wait_left;
    bit          m_green;
    bit          m_red;
    logic [15:0] exp_q[$];
    int          errors;
    int          checks;
    int          cyc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] hex_of(input phase_t p);
        case (p)
            P_WAIT:  return {7'h06, 7'h2B};
            P_WRONG: return {7'h06, 7'h06};
            P_GO:    return {7'h02, 7'h40};
            P_STOP:  return {7'h12, 7'h0C};
            default: return {7'h7F, 7'h7F};
        endcase
    endfunction

    // One clock: apply inputs at the falling edge, advance the model to what
    // the next rising edge must produce, queue that expectation.
    task automatic step(input bit rst, input bit ent, input bit ext,
                        input logic [1:0] p1, input logic [1:0] p2);
        bit ok;
        @(negedge clk);
        reset_n         = rst;
        sensor_entrance = ent;
        sensor_exit     = ext;
        password_1      = p1;
        password_2      = p2;
        ok = (p1 == 2'b01) && (p2 == 2'b10);
        if (rst) begin
            ph = P_IDLE;
            wait_left = 0;
            m_green = 1'b0;
            m_red = 1'b0;
        end else begin
            case (ph)
                P_IDLE: if (ent) begin ph = P_WAIT; wait_left = WAIT_CYCLES; end
                P_WAIT: begin
                    wait_left--;
                    if (wait_left == 0) ph = ok ? P_GO : P_WRONG;
                end
                P_WRONG, P_STOP: if (ok) ph = P_GO;
                P_GO: begin
                    if (ent && ext) ph = P_STOP;
                    else if (ext)   ph = P_IDLE;
                end
                default: ph = P_IDLE;
            endcase
            case (ph)
                P_WAIT:          begin m_green = 1'b0; m_red = 1'b1; end
                P_WRONG, P_STOP: begin m_green = 1'b0; m_red = ~m_red; end
                P_GO:            begin m_green = ~m_green; m_red = 1'b0; end
                default:         begin m_green = 1'b0; m_red = 1'b0; end
            endcase
        end
        exp_q.push_back({m_green, m_red, hex_of(ph)});
        if (rst) begin
            #1;
            check("async_reset_outputs", {16'h0, GREEN_LED, RED_LED, HEX_1, HEX_2}, {16'h0, 2'b00, 14'h3FFF});
            check("async_reset_counter", dut.counter, 32'h0);
        end
    endtask

    // Monitor: outputs are valid every cycle, compare one entry per rising edge.
    initial begin
        logic [15:0] e;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("cycle%0d {grn,red,hex1,hex2}", cyc),
                      {16'h0, GREEN_LED, RED_LED, HEX_1, HEX_2}, {16'h0, e});
            end
        end
    end

    localparam logic [1:0] OK1 = 2'b01;
    localparam logic [1:0] OK2 = 2'b10;

    initial begin
        errors = 0;
        checks = 0;
        ph = P_IDLE;
        wait_left = 0;
        m_green = 1'b0;
        m_red = 1'b0;
        reset_n = 1'b1;
        sensor_entrance = 1'b0;
        sensor_exit = 1'b0;
        password_1 = 2'b00;
        password_2 = 2'b00;

        repeat (2) step(1, 0, 0, 2'b00, 2'b00);
        repeat (2) step(0, 0, 0, 2'b00, 2'b00);

        // Correct password held through the wait, green toggles, exit alone.
        step(0, 1, 0, OK1, OK2);
        repeat (WAIT_CYCLES) step(0, 0, 0, OK1, OK2);
        repeat (3) step(0, 0, 0, OK1, OK2);
        step(0, 0, 1, OK1, OK2);
        step(0, 0, 0, 2'b00, 2'b00);

        // Wrong password, red toggles; sensors ignored; then fix it.
        step(0, 1, 0, 2'b00, 2'b00);
        repeat (WAIT_CYCLES) step(0, 0, 0, 2'b00, 2'b00);
        repeat (3) step(0, 1, 1, 2'b00, 2'b00);
        step(0, 0, 0, OK1, OK2);
        // Tailgating -> STOP, wrong holds, correct releases, exit.
        step(0, 1, 1, 2'b00, 2'b00);
        repeat (2) step(0, 0, 0, 2'b11, 2'b10);
        step(0, 0, 0, OK1, OK2);
        step(0, 0, 1, OK1, OK2);

        // Reset in the middle of the wait, then a fresh entry.
        step(0, 1, 0, OK1, OK2);
        repeat (2) step(0, 0, 0, OK1, OK2);
        step(1, 0, 0, OK1, OK2);
        step(0, 0, 0, OK1, OK2);
        step(0, 1, 0, OK1, OK2);
        step(0, 0, 0, OK1, OK2);
        step(1, 0, 0, 2'b00, 2'b00);
        step(0, 0, 0, 2'b00, 2'b00);

        // Only the decision edge samples the password, in both directions.
        step(0, 1, 0, OK1, OK2);
        repeat (WAIT_CYCLES - 1) step(0, 0, 0, OK1, OK2);
        step(0, 0, 0, 2'b01, 2'b11);
        step(0, 0, 0, OK1, OK2);
        step(0, 0, 1, OK1, OK2);
        step(0, 1, 0, 2'b00, 2'b01);
        repeat (WAIT_CYCLES - 1) step(0, 0, 0, 2'b10, 2'b01);
        step(0, 0, 0, OK1, OK2);
        step(0, 0, 1, 2'b00, 2'b00);

        for (int i = 0; i < 600; i++) begin
            bit         r, en, ex;
            logic [1:0] a, b;
            r  = ($urandom_range(0, 79) == 0);
            en = ($urandom_range(0, 2) == 0);
            ex = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                a = OK1;
                b = OK2;
            end else begin
                a = 2'($urandom);
                b = 2'($urandom);
            end
            step(r, en, ex, a, b);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
